// File: rtl/oven_ctrl_fsm.sv
// oven_ctrl_fsm
//   Control stage directly downstream of the countdown timer. Conditions the
//   start/stop buttons and the door sensor, sequences IDLE/COOK/PAUSE/DONE,
//   drives the timer count enable (mag_on) and its synchronous clear, and
//   produces a fixed-length done alert.
//
// Parameters
//   BEEP_CYCLES : cycles done_beep stays high in DONE (1..255)
//   CNT_W       : beep counter width, 2**CNT_W > BEEP_CYCLES
//
// Ports
//   clk         in   system clock, rising edge
//   clrn        in   synchronous active-low reset
//   startn      in   start button, active-low, asynchronous
//   stopn       in   stop/cancel button, active-low, asynchronous
//   door_closed in   door sensor, 1 = closed, asynchronous
//   timer_zero  in   timer count is 0:00 (same clock domain)
//   mag_on      out  magnetron on / timer count enable
//   timer_clrn  out  one-cycle active-low timer clear
//   load_ok     out  keypad may load the timer (IDLE only)
//   done_beep   out  done alert
//   state       out  IDLE=00 COOK=01 PAUSE=10 DONE=11
module oven_ctrl_fsm #(
   parameter int unsigned BEEP_CYCLES = 8,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic       mag_on,
   output logic       timer_clrn,
   output logic       load_ok,
   output logic       done_beep,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COOK  = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] BEEP_LOAD = CNT_W'(BEEP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           st, st_nxt;
   logic [CNT_W-1:0] beep_cnt, cnt_nxt;
   logic             clr_nxt;

   logic start_s1, start_s2, start_s3;
   logic stop_s1,  stop_s2,  stop_s3;
   logic door_s1,  door_s2;
   logic start_ev, stop_ev;

   // Buttons reset to "released" so reset itself cannot look like a press;
   // the door resets to "open" so nothing can cook until it is seen closed.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         start_s1 <= 1'b1;
         start_s2 <= 1'b1;
         start_s3 <= 1'b1;
         stop_s1  <= 1'b1;
         stop_s2  <= 1'b1;
         stop_s3  <= 1'b1;
         door_s1  <= 1'b0;
         door_s2  <= 1'b0;
      end else begin
         start_s1 <= startn;
         start_s2 <= start_s1;
         start_s3 <= start_s2;
         stop_s1  <= stopn;
         stop_s2  <= stop_s1;
         stop_s3  <= stop_s2;
         door_s1  <= door_closed;
         door_s2  <= door_s1;
      end
   end

   // Falling-edge detect: one pulse per press, a held button is silent.
   assign start_ev = start_s3 & ~start_s2;
   assign stop_ev  = stop_s3  & ~stop_s2;

   always_comb begin
      st_nxt  = st;
      cnt_nxt = beep_cnt;
      clr_nxt = 1'b0;
      case (st)
         IDLE: begin
            if (stop_ev)
               clr_nxt = 1'b1;
            else if (start_ev && door_s2 && !timer_zero)
               st_nxt = COOK;
         end
         COOK: begin
            // Expiry beats door/stop so the alert is never lost.
            if (timer_zero) begin
               st_nxt  = DONE;
               cnt_nxt = BEEP_LOAD;
            end else if (!door_s2 || stop_ev) begin
               st_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (stop_ev) begin
               st_nxt  = IDLE;
               clr_nxt = 1'b1;
            end else if (timer_zero) begin
               st_nxt = IDLE;
            end else if (start_ev && door_s2) begin
               st_nxt = COOK;
            end
         end
         DONE: begin
            // <= 1 rather than == 1 so a zero count can never strand us here.
            if (stop_ev || beep_cnt <= CNT_ONE) begin
               st_nxt  = IDLE;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = beep_cnt - CNT_ONE;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they switch on the same
   // edge as the state register, with no path from the raw inputs.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         st         <= IDLE;
         beep_cnt   <= '0;
         mag_on     <= 1'b0;
         timer_clrn <= 1'b1;
         load_ok    <= 1'b1;
         done_beep  <= 1'b0;
      end else begin
         st         <= st_nxt;
         beep_cnt   <= cnt_nxt;
         mag_on     <= (st_nxt == COOK);
         timer_clrn <= ~clr_nxt;
         load_ok    <= (st_nxt == IDLE);
         done_beep  <= (st_nxt == DONE);
      end
   end

   assign state = st;

endmodule

// File: tb/tb_oven_ctrl_fsm.sv
module tb_oven_ctrl_fsm;

   localparam int BEEP    = 8;
   localparam int M_IDLE  = 0;
   localparam int M_COOK  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clk = 1'b0;
   logic       clrn, startn, stopn, door_closed, timer_zero;
   logic       mag_on, timer_clrn, load_ok, done_beep;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;
   int beeps;

   always #5 clk = ~clk;

   oven_ctrl_fsm #(.BEEP_CYCLES(BEEP), .CNT_W(8)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .startn     (startn),
      .stopn      (stopn),
      .door_closed(door_closed),
      .timer_zero (timer_zero),
      .mag_on     (mag_on),
      .timer_clrn (timer_clrn),
      .load_ok    (load_ok),
      .done_beep  (done_beep),
      .state      (state)
   );

   // ---------------- reference model ----------------
   // Mode plus "cycles spent in DONE"; inputs seen through a sample history:
   // a press is recognised 3 samples back released, 2 samples back pressed;
   // the door is the value sampled 2 edges ago.
   typedef struct packed {
      int mode;
      int age;
      bit clr;
   } mres_t;

   mres_t  m;
   bit [2:0] h_start, h_stop;
   bit [1:0] h_door;

   function automatic mres_t model_next(int mode, int age, bit st_ev, bit sp_ev,
                                        bit door, bit tz);
      mres_t r;
      r.mode = mode;
      r.age  = age;
      r.clr  = 1'b0;
      case (mode)
         M_IDLE:
            if (sp_ev) r.clr = 1'b1;
            else if (st_ev && door && !tz) r.mode = M_COOK;
         M_COOK:
            if (tz) begin r.mode = M_DONE; r.age = 1; end
            else if (!door || sp_ev) r.mode = M_PAUSE;
         M_PAUSE:
            if (sp_ev) begin r.mode = M_IDLE; r.clr = 1'b1; end
            else if (tz) r.mode = M_IDLE;
            else if (st_ev && door) r.mode = M_COOK;
         default:
            if (sp_ev || age >= BEEP) begin r.mode = M_IDLE; r.age = 0; end
            else r.age = age + 1;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (!clrn) begin
         m       <= '{mode: M_IDLE, age: 0, clr: 1'b0};
         h_start <= 3'b111;
         h_stop  <= 3'b111;
         h_door  <= 2'b00;
      end else begin
         m <= model_next(m.mode, m.age, h_start[2] & ~h_start[1],
                         h_stop[2] & ~h_stop[1], h_door[1], timer_zero);
         h_start <= {h_start[1:0], startn};
         h_stop  <= {h_stop[1:0], stopn};
         h_door  <= {h_door[0], door_closed};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_state",      32'(state),      32'(m.mode));
         check("m_mag_on",     32'(mag_on),     32'(m.mode == M_COOK));
         check("m_load_ok",    32'(load_ok),    32'(m.mode == M_IDLE));
         check("m_done_beep",  32'(done_beep),  32'(m.mode == M_DONE));
         check("m_timer_clrn", 32'(timer_clrn), 32'(!m.clr));
         check("clr_with_mag", 32'(!timer_clrn && mag_on), 32'd0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clrn = 1'b0; startn = 1'b0; stopn = 1'b1; door_closed = 1'b0; timer_zero = 1'b0;

      // reset held 2 cycles with start pressed
      tick(1);
      chk_en = 1'b1;
      tick(1);
      check("rst_state",      32'(state), 32'd0);
      check("rst_mag_on",     32'(mag_on), 32'd0);
      check("rst_timer_clrn", 32'(timer_clrn), 32'd1);
      check("rst_done_beep",  32'(done_beep), 32'd0);
      check("rst_load_ok",    32'(load_ok), 32'd1);
      clrn = 1'b1;
      tick(5);
      check("rst_release_idle", 32'(state), 32'd0);
      startn = 1'b1;
      tick(2);

      // normal cook to done
      door_closed = 1'b1;
      tick(3);
      startn = 1'b0;
      tick(2);
      check("cook_lat_early", 32'(state), 32'd0);
      tick(1);
      check("cook_state",   32'(state), 32'd1);
      check("cook_mag_on",  32'(mag_on), 32'd1);
      check("cook_load_ok", 32'(load_ok), 32'd0);
      startn = 1'b1;
      tick(2);
      timer_zero = 1'b1;
      tick(1);
      check("done_state", 32'(state), 32'd3);
      beeps = 0;
      for (int i = 0; i < 20 && done_beep === 1'b1; i++) begin
         beeps++;
         tick(1);
      end
      check("done_beep_len", 32'(beeps), 32'd8);
      check("done_to_idle",  32'(state), 32'd0);
      timer_zero = 1'b0;
      tick(2);

      // pause / resume / cancel
      startn = 1'b0; tick(3); startn = 1'b1;
      check("pr_cook", 32'(state), 32'd1);
      tick(2);
      door_closed = 1'b0;
      tick(2);
      check("door_lat_early", 32'(state), 32'd1);
      tick(1);
      check("door_pause",  32'(state), 32'd2);
      check("door_mag_off", 32'(mag_on), 32'd0);
      door_closed = 1'b1; startn = 1'b0;
      tick(3);
      check("resume_cook", 32'(state), 32'd1);
      startn = 1'b1; tick(2);
      stopn = 1'b0; tick(3);
      check("stop_pause", 32'(state), 32'd2);
      stopn = 1'b1; tick(2);
      stopn = 1'b0; tick(3);
      check("cancel_idle", 32'(state), 32'd0);
      check("cancel_clr",  32'(timer_clrn), 32'd0);
      tick(1);
      check("cancel_clr_end", 32'(timer_clrn), 32'd1);
      stopn = 1'b1; tick(2);

      // blocked starts
      door_closed = 1'b0; tick(3);
      startn = 1'b0; tick(3);
      check("blk_door", 32'(state), 32'd0);
      startn = 1'b1; tick(2);
      door_closed = 1'b1; timer_zero = 1'b1; tick(3);
      startn = 1'b0; tick(3);
      check("blk_tz", 32'(state), 32'd0);
      startn = 1'b1; timer_zero = 1'b0; tick(2);

      // simultaneous start+stop in COOK, then held start in PAUSE
      startn = 1'b0; tick(3); startn = 1'b1;
      check("sim_cook", 32'(state), 32'd1);
      tick(2);
      startn = 1'b0; stopn = 1'b0; tick(3);
      check("sim_stop_wins", 32'(state), 32'd2);
      startn = 1'b1; stopn = 1'b1; tick(2);
      door_closed = 1'b0; tick(3);
      startn = 1'b0; tick(20);
      check("held_start", 32'(state), 32'd2);
      startn = 1'b1; tick(2);
      door_closed = 1'b1; stopn = 1'b0; tick(3);
      check("held_cleanup", 32'(state), 32'd0);
      stopn = 1'b1; tick(2);

      // early abort in DONE
      startn = 1'b0; tick(3); startn = 1'b1;
      check("ab_cook", 32'(state), 32'd1);
      tick(2);
      timer_zero = 1'b1; tick(1);
      check("ab_done", 32'(state), 32'd3);
      tick(2);
      check("ab_beep3", 32'(done_beep), 32'd1);
      stopn = 1'b0; tick(2);
      check("ab_lat_early", 32'(state), 32'd3);
      tick(1);
      check("ab_idle", 32'(state), 32'd0);
      check("ab_beep_off", 32'(done_beep), 32'd0);
      stopn = 1'b1; timer_zero = 1'b0; tick(2);

      // reset mid-cook
      startn = 1'b0; tick(3); startn = 1'b1;
      check("rc_cook", 32'(state), 32'd1);
      tick(2);
      clrn = 1'b0; tick(1);
      check("rc_mag_off", 32'(mag_on), 32'd0);
      check("rc_state",   32'(state), 32'd0);
      clrn = 1'b1; tick(3);

      // randomized soak against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)  startn      = ~startn;
         if ($urandom_range(0, 11) == 0) stopn       = ~stopn;
         if ($urandom_range(0, 24) == 0) door_closed = ~door_closed;
         if ($urandom_range(0, 19) == 0) timer_zero  = ~timer_zero;
         clrn = ($urandom_range(0, 299) != 0);
         tick(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
